// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared combinational 32-bit shifter.
// Only one operation is in flight at a time: IDLE (accept) -> EXEC (shift) -> RESP (return).
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [1:0]         req0_type,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req1_type,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_data,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_data,
    output logic [DATA_W-1:0]  sh_a,
    output logic [SHAMT_W-1:0] sh_shamt,
    output logic [1:0]         sh_type,
    input  logic [DATA_W-1:0]  sh_r,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [DATA_W-1:0]    sh_a_q, sh_a_d;
    logic [SHAMT_W-1:0]   sh_shamt_q, sh_shamt_d;
    logic [1:0]           sh_type_q, sh_type_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic                 grant0, grant1, accept;

    // Round-robin winner: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept = grant0 | grant1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        busy       = (state_q != IDLE);
    end

    always_comb begin
        sh_a_d       = sh_a_q;
        sh_shamt_d   = sh_shamt_q;
        sh_type_d    = sh_type_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        if (accept) begin
            sh_a_d       = grant1 ? req1_a     : req0_a;
            sh_shamt_d   = grant1 ? req1_shamt : req0_shamt;
            sh_type_d    = grant1 ? req1_type  : req0_type;
            owner_d      = grant1;
            last_grant_d = grant1;
        end
        if (state_q == EXEC) result_d = sh_r;
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a_q       <= '0;
            sh_shamt_q   <= '0;
            sh_type_q    <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
        end else begin
            sh_a_q       <= sh_a_d;
            sh_shamt_q   <= sh_shamt_d;
            sh_type_q    <= sh_type_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
        end
    end

    assign sh_a      = sh_a_q;
    assign sh_shamt  = sh_shamt_q;
    assign sh_type   = sh_type_q;
    assign rsp0_data = result_q;
    assign rsp1_data = result_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: table of single operations plus hand-written
// back-pressure, reset-in-RESP and contention sequences. A behavioural shifter drives sh_r.
module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_type, req1_type;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] sh_a, sh_r;
    logic [4:0]  sh_shamt;
    logic [1:0]  sh_type;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_type  (req0_type),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_type  (req1_type),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .sh_a       (sh_a),
        .sh_shamt   (sh_shamt),
        .sh_type    (sh_type),
        .sh_r       (sh_r),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared shifter: 00 SLL, 01 SRL, 11 SRA, 10 returns zero.
    always_comb begin
        case (sh_type)
            2'b00:   sh_r = sh_a << sh_shamt;
            2'b01:   sh_r = sh_a >> sh_shamt;
            2'b11:   sh_r = $unsigned($signed(sh_a) >>> sh_shamt);
            default: sh_r = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic [4:0]  s0;
        logic [1:0]  t0;
        logic        v1;
        logic [31:0] a1;
        logic [4:0]  s1;
        logic [1:0]  t1;
        logic        win;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    // One full operation: accept, EXEC, RESP with data check, handshake back to IDLE.
    task automatic do_op(input vec_t v);
        @(negedge clk);
        req0_valid = v.v0; req0_a = v.a0; req0_shamt = v.s0; req0_type = v.t0;
        req1_valid = v.v1; req1_a = v.a1; req1_shamt = v.s1; req1_type = v.t1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check("idle_req0_ready", req0_ready, !v.win);
        check("idle_req1_ready", req1_ready, v.win);
        check("idle_busy", busy, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        // The non-owner's ready is raised early; it must be ignored.
        if (v.win) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        #1;
        check("exec_busy", busy, 1);
        check("exec_sh_a", sh_a, v.win ? v.a1 : v.a0);
        check("exec_sh_shamt", sh_shamt, v.win ? v.s1 : v.s0);
        check("exec_sh_type", sh_type, v.win ? v.t1 : v.t0);
        check("exec_rsp_valids", {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk);
        #1;
        check("resp_rsp0_valid", rsp0_valid, !v.win);
        check("resp_rsp1_valid", rsp1_valid, v.win);
        check("resp_data", v.win ? rsp1_data : rsp0_data, v.exp);
        check("resp_no_ready", {req1_ready, req0_ready}, 0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check("done_busy", busy, 0);
        check("done_rsp_valids", {rsp1_valid, rsp0_valid}, 0);
    endtask

    initial begin
        int grants[$];

        vecs[0] = '{1'b1, 32'h0000_0001, 5'd4,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0000_0010};
        vecs[1] = '{1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'h8000_0000, 5'd4,  2'b01, 1'b1, 32'h0800_0000};
        vecs[2] = '{1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'h8000_0000, 5'd4,  2'b11, 1'b1, 32'hF800_0000};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd7,  2'b10, 1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h1234_5678, 5'd31, 2'b11, 1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b00, 1'b1, 32'h8000_0000};
        // Ties: last grant was 1, so 0 wins; then 1 wins.
        vecs[6] = '{1'b1, 32'hA5A5_A5A5, 5'd0,  2'b01, 1'b1, 32'h0000_00FF, 5'd8,  2'b00, 1'b0, 32'hA5A5_A5A5};
        vecs[7] = '{1'b1, 32'h0000_0003, 5'd1,  2'b00, 1'b1, 32'h8000_0001, 5'd1,  2'b11, 1'b1, 32'hC000_0000};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_shamt = '0; req0_type = '0;
        req1_valid = 1'b0; req1_a = '0; req1_shamt = '0; req1_type = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_readies", {req1_ready, req0_ready}, 0);
        check("rst_rsp_valids", {rsp1_valid, rsp0_valid}, 0);
        check("rst_sh_a", sh_a, 0);
        check("rst_sh_shamt", sh_shamt, 0);
        check("rst_sh_type", sh_type, 0);
        check("rst_rsp0_data", rsp0_data, 0);
        check("rst_rsp1_data", rsp1_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Back-pressure: req0 result held for 5 cycles while req1 waits.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h3; req0_shamt = 5'd2; req0_type = 2'b00;
        #1;
        check("bp_req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h1; req1_shamt = 5'd3; req1_type = 2'b00;
        #1;
        check("bp_exec_req1_ready", req1_ready, 0);
        check("bp_exec_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_rsp0_valid", rsp0_valid, 1);
            check("bp_hold_rsp0_data", rsp0_data, 32'hC);
            check("bp_hold_req1_ready", req1_ready, 0);
            check("bp_hold_busy", busy, 1);
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        check("bp_hs_rsp0_valid", rsp0_valid, 1);
        check("bp_hs_req1_ready", req1_ready, 0);
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        check("bp_after_rsp0_valid", rsp0_valid, 0);
        check("bp_after_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("bp_r1_sh_a", sh_a, 32'h1);
        check("bp_r1_sh_shamt", sh_shamt, 5'd3);
        @(negedge clk);
        #1;
        check("bp_r1_rsp1_valid", rsp1_valid, 1);
        check("bp_r1_rsp1_data", rsp1_data, 32'h8);
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        check("bp_r1_done_busy", busy, 0);

        // Reset while req0's response is pending; req0 won last, so only reset restores its priority.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h1; req0_shamt = 5'd5; req0_type = 2'b00;
        #1;
        check("rr_req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rr_rsp0_valid", rsp0_valid, 1);
        check("rr_rsp0_data", rsp0_data, 32'h20);
        #2 rst = 1'b1;
        #1;
        check("rr_async_rsp0_valid", rsp0_valid, 0);
        check("rr_async_busy", busy, 0);
        check("rr_async_sh_a", sh_a, 0);
        check("rr_async_rsp0_data", rsp0_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Contention from reset: both continuously valid, grants must alternate 0,1,0,1.
        req0_valid = 1'b1; req0_a = 32'h1; req0_shamt = 5'd1; req0_type = 2'b00;
        req1_valid = 1'b1; req1_a = 32'h1; req1_shamt = 5'd2; req1_type = 2'b00;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("ct_not_both_ready", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) check("ct_rsp0_data", rsp0_data, 32'h2);
            if (rsp1_valid) check("ct_rsp1_data", rsp1_data, 32'h4);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("ct_grant_count", grants.size(), 4);
        for (int g = 0; g < grants.size() && g < 4; g++)
            check("ct_grant_order", grants[g], g % 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Two-requester scheduler that shares one combinational 32-bit shift unit (SLL/SRL/SRA, type-coded) between requesters, e.g. the ALU-issue path and the load/store byte-aligner. It arbitrates round-robin and registers the winner's operands onto the shared shifter inputs. It then captures the shifter result and returns it on a per-requester valid/ready response channel. Only one operation is in flight at a time.

Parameters:
DATA_W, 32, operand/result width. Fixed at 32 for RV32I.
SHAMT_W, 5, shift-amount width. Must equal log2(DATA_W).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  DATA_W  requester 0 operand
req0_shamt  input  SHAMT_W  requester 0 shift amount
req0_type  input  2  requester 0 op: 00 SLL, 01 SRL, 11 SRA, 10 reserved
req1_valid, req1_ready, req1_a, req1_shamt, req1_type  same as above, requester 1
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 takes result
rsp0_data  output  DATA_W  result for requester 0
rsp1_valid, rsp1_ready, rsp1_data  same as above, requester 1
sh_a  output  DATA_W  operand to shared shifter
sh_shamt  output  SHAMT_W  shamt to shared shifter
sh_type  output  2  type to shared shifter
sh_r  input  DATA_W  shifter result, combinational from sh_*
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset state:
  - state=IDLE, last_grant=1 (requester 0 has priority first).
  - Operand registers (sh_a, sh_shamt, sh_type) = 0. Result register = 0. Owner register = 0.
  - All ready/valid outputs = 0. busy = 0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: high only for the arbitration winner, and only in IDLE. Never high for both requesters.
  - Winner rule: if exactly one reqN_valid is high, that requester wins. If both are high, the requester != last_grant wins.
  - On accept (valid&ready): latch reqN_a, reqN_shamt and reqN_type into the sh_* registers. Set owner=N and last_grant=N. Go to EXEC.
  - With no valid request, stay in IDLE. Registers hold.
- EXEC (one cycle):
  - sh_* are stable from registers.
  - At the end of the cycle, capture sh_r into the result register and go to RESP.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_data=result. The other rsp_valid=0.
  - Hold valid and data stable until rsp[owner]_ready=1. On that cycle go to IDLE.
  - No new request is accepted in the RESP cycle.
- Latency: accept in cycle T; rsp_valid high from cycle T+2. Minimum 3 cycles per op per shifter.
- Output stability:
  - rspN_data is driven with the result register at all times.
  - Consumers qualify rspN_data with rspN_valid only.
- Type 10: no special handling. The shifter returns 0, and 0 is returned as a normal response.
- Requester rules:
  - A requester must hold reqN_valid and its operands stable until reqN_ready.
  - Dropping valid before acceptance is allowed and forfeits the slot. No grant is recorded.
- Starvation: with both requesters continuously valid, grants alternate 0,1,0,1.
- Reset mid-operation: any in-flight op in EXEC or RESP is discarded without a response. Arbitration restarts with requester 0 priority.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
1. Single SLL: req0 a=0x00000001, shamt=4, type=00 -> req0_ready at T; rsp0_valid at T+2 with data 0x00000010; rsp1_valid stays 0.
2. SRL vs SRA: req1 a=0x80000000, shamt=4, type=01 -> rsp1_data=0x08000000. Then type=11 -> rsp1_data=0xF8000000.
3. Contention: both valid from reset, req0 shamt=1, req1 shamt=2, a=0x1 SLL -> grant order 0,1,0,1; rsp0_data=0x2, rsp1_data=0x4; never both ready in one cycle.
4. Back-pressure: rsp0_ready=0 for 5 cycles, with req1_valid high meanwhile -> rsp0_valid and rsp0_data held; req1_ready=0 until the cycle after rsp0 handshake; busy=1 throughout.
5. Reserved type: type=10, a=0xFFFFFFFF -> rsp_data=0x00000000 with normal 2-cycle latency.
6. Reset in RESP: assert rst while rsp0_valid=1 -> rsp0_valid drops immediately (async); after release, state IDLE; with both valid, requester 0 is granted first.
